// File: rtl/seq_mult_pkg.sv
// seq_mult_pkg: definitions shared by the sequential multiplier files.
//   state_t       - controller states (IDLE / RUN / DONE)
//   WIDTH_DEFAULT - default operand width in bits
package seq_mult_pkg;

  localparam int WIDTH_DEFAULT = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/seq_mult_if.sv
// seq_mult_if: operand/result handshake bundle of the sequential multiplier.
//   in_valid/in_ready/a/b       - operand channel (producer -> multiplier)
//   out_valid/out_ready/product - result channel (multiplier -> consumer)
// Modports: slave = multiplier side, master = producer/consumer side.
interface seq_mult_if
  import seq_mult_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
);

  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] product;

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, product
  );

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, product
  );

endinterface

// File: rtl/seq_mult_add_row.sv
// seq_mult_add_row: N-bit ripple-carry add/subtract row built from one
// full-adder cell per bit.
//   x, y - operands
//   sub  - 0: s = x + y, 1: s = x - y (y inverted, carry-in forced to 1)
//   s    - N-bit sum; the carry out of the top cell is not needed by the
//          multiplier and is therefore not generated
module seq_mult_add_row #(
  parameter int N = 6
) (
  input  logic [N-1:0] x,
  input  logic [N-1:0] y,
  input  logic         sub,
  output logic [N-1:0] s
);

  logic [N-1:0] carry;
  logic [N-1:0] y_eff;

  assign carry[0] = sub;

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_fa
      assign y_eff[gi] = y[gi] ^ sub;
      assign s[gi]     = x[gi] ^ y_eff[gi] ^ carry[gi];
      if (gi < N - 1) begin : g_carry
        assign carry[gi+1] = (x[gi] & y_eff[gi]) | (carry[gi] & (x[gi] ^ y_eff[gi]));
      end
    end
  endgenerate

endmodule

// File: rtl/seq_mult.sv
// seq_mult: shift-add sequential multiplier, one partial product per cycle.
//   clk  - clock, all state changes on the rising edge
//   rst  - synchronous active-high reset
//   bus  - seq_mult_if.slave: operands a/b accepted on in_valid & in_ready,
//          product (2*WIDTH bits) offered on out_valid until out_ready
// Parameter WIDTH: operand width, 2..32.
// Optional macro SEQ_MULT_SIGNED_EN: treat a/b as two's complement; the
// final step subtracts the multiplicand. Default build is unsigned only.
//
// Timing: accept in IDLE, WIDTH RUN cycles, product held in DONE until the
// consumer takes it; out_valid rises WIDTH+1 cycles after the transfer cycle.
module seq_mult
  import seq_mult_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic      clk,
  input  logic      rst,
  seq_mult_if.slave bus
);

  localparam int CW = $clog2(WIDTH) + 1;

  state_t             state_reg,  state_next;
  logic [2*WIDTH-1:0] acc_reg,    acc_next;
  logic [WIDTH-1:0]   mcand_reg,  mcand_next;
  logic [WIDTH-1:0]   mplier_reg, mplier_next;
  logic [CW-1:0]      step_reg,   step_next;

  logic               last_step;
  logic [WIDTH:0]     row_x;
  logic [WIDTH:0]     row_y;
  logic [WIDTH:0]     row_s;
  logic               row_sub;

  assign last_step = (step_reg == CW'(WIDTH - 1));

  // The multiplier register shifts right every step, so its LSB is always
  // the multiplier bit belonging to the current step.
`ifdef SEQ_MULT_SIGNED_EN
  // Upper accumulator half and multiplicand are sign-extended; the MSB of a
  // two's-complement multiplier carries negative weight, hence subtract.
  assign row_x   = {acc_reg[2*WIDTH-1], acc_reg[2*WIDTH-1:WIDTH]};
  assign row_y   = mplier_reg[0] ? {mcand_reg[WIDTH-1], mcand_reg} : '0;
  assign row_sub = mplier_reg[0] & last_step;
`else
  assign row_x   = {1'b0, acc_reg[2*WIDTH-1:WIDTH]};
  assign row_y   = mplier_reg[0] ? {1'b0, mcand_reg} : '0;
  assign row_sub = 1'b0;
`endif

  seq_mult_add_row #(
    .N (WIDTH + 1)
  ) u_add_row (
    .x   (row_x),
    .y   (row_y),
    .sub (row_sub),
    .s   (row_s)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      acc_reg    <= '0;
      mcand_reg  <= '0;
      mplier_reg <= '0;
      step_reg   <= '0;
    end else begin
      state_reg  <= state_next;
      acc_reg    <= acc_next;
      mcand_reg  <= mcand_next;
      mplier_reg <= mplier_next;
      step_reg   <= step_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    acc_next    = acc_reg;
    mcand_next  = mcand_reg;
    mplier_next = mplier_reg;
    step_next   = step_reg;

    case (state_reg)
      IDLE: begin
        if (bus.in_valid) begin
          mcand_next  = bus.a;
          mplier_next = bus.b;
          acc_next    = '0;
          step_next   = '0;
          state_next  = RUN;
        end
      end
      RUN: begin
        // Row result (with its carry/sign bit) becomes the new upper half;
        // its LSB shifts into the lower half.
        acc_next    = {row_s, acc_reg[WIDTH-1:1]};
        mplier_next = mplier_reg >> 1;
        step_next   = step_reg + CW'(1);
        if (last_step) begin
          state_next = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign bus.in_ready  = (state_reg == IDLE);
  assign bus.out_valid = (state_reg == DONE);
  assign bus.product   = (state_reg == DONE) ? acc_reg : '0;

endmodule

// File: tb/tb_seq_mult.sv
// tb_seq_mult: directed + sweep bench for seq_mult with a scoreboard queue.
// Honours SEQ_MULT_SIGNED_EN for the reference multiplication.
module tb_seq_mult;

  localparam int W = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  seq_mult_if #(.WIDTH(W)) bus ();

  seq_mult #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int pass_cnt  = 0;
  int total_cnt = 0;

  logic [2*W-1:0] exp_q[$];

  function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] x, input logic [W-1:0] y);
    longint sx;
    longint sy;
    longint p;
`ifdef SEQ_MULT_SIGNED_EN
    sx = longint'($signed(x));
    sy = longint'($signed(y));
`else
    sx = longint'(x);
    sy = longint'(y);
`endif
    p = sx * sy;
    return p[2*W-1:0];
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  // Present operands for one cycle starting at a negedge; returns at the
  // negedge after the accept edge (first RUN cycle).
  task automatic send(input logic [W-1:0] av, input logic [W-1:0] bv, input bit push);
    @(negedge clk);
    check("in_ready_before_send", bus.in_ready, 1);
    bus.a        = av;
    bus.b        = bv;
    bus.in_valid = 1'b1;
    if (push) exp_q.push_back(ref_mul(av, bv));
    @(negedge clk);
    bus.in_valid = 1'b0;
    $display("send a=%0d b=%0d", av, bv);
  endtask

  // Wait for the result, stall the consumer, then take it and pop/compare.
  task automatic recv(input int stall, input bit chk_lat, input bit hold_in_valid);
    int cyc;
    logic [2*W-1:0] exp;
    cyc = 1;
    bus.out_ready = 1'b0;
    while (!bus.out_valid && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    if (exp_q.size() == 0) begin
      check("scoreboard_empty", 0, 1);
      return;
    end
    exp = exp_q.pop_front();
    if (!bus.out_valid) begin
      check("out_valid_timeout", 0, 1);
      return;
    end
    if (chk_lat) check("latency", cyc, W + 1);
    for (int i = 0; i < stall; i++) begin
      if (hold_in_valid) begin
        bus.in_valid = 1'b1;
        bus.a        = 5'd1;
        bus.b        = 5'd1;
      end
      check("product_stall", bus.product, exp);
      check("in_ready_done", bus.in_ready, 0);
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    check("out_valid_at_take", bus.out_valid, 1);
    check("product", bus.product, exp);
    $display("recv product=0x%0h expected=0x%0h stall=%0d", bus.product, exp, stall);
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check("out_valid_after_take", bus.out_valid, 0);
    check("product_zero_idle", bus.product, 0);
    check("in_ready_after_take", bus.in_ready, 1);
  endtask

  task automatic expect_quiet(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check(tag, bus.out_valid, 0);
      check("product_zero_quiet", bus.product, 0);
    end
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.a         = '0;
    bus.b         = '0;

    // Reset state
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("reset_in_ready", bus.in_ready, 1);
    check("reset_out_valid", bus.out_valid, 0);
    check("reset_product", bus.product, 0);
    rst = 1'b0;
    @(negedge clk);
    check("post_reset_in_ready", bus.in_ready, 1);

    // Max operands, latency
    send(5'd31, 5'd31, 1'b1);
    check("in_ready_run", bus.in_ready, 0);
    recv(0, 1'b1, 1'b0);

    // Long consumer stall with in_valid held high during DONE
    send(5'd13, 5'd7, 1'b1);
    recv(10, 1'b1, 1'b1);

    // Second request during RUN must be ignored
    send(5'd5, 5'd6, 1'b1);
    bus.a        = 5'd3;
    bus.b        = 5'd3;
    bus.in_valid = 1'b1;
    check("in_ready_run_pulse", bus.in_ready, 0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    recv(0, 1'b0, 1'b0);
    expect_quiet("no_second_result", W + 3);

    // Reset on the 3rd RUN cycle aborts the operation
    send(5'd9, 5'd9, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("in_ready_after_abort", bus.in_ready, 1);
    expect_quiet("aborted_no_out_valid", W + 3);
    send(5'd2, 5'd3, 1'b1);
    recv(1, 1'b1, 1'b0);

    // Sign-boundary operands (signed in the signed build)
    send(5'b10000, 5'b10000, 1'b1);
    recv(0, 1'b1, 1'b0);
    send(5'b10000, 5'b01111, 1'b1);
    recv(2, 1'b1, 1'b0);
    send(5'd0, 5'b11111, 1'b1);
    recv(0, 1'b1, 1'b0);
    send(5'b11111, 5'd0, 1'b1);
    recv(0, 1'b1, 1'b0);

    // Exhaustive sweep with random consumer stalls
    for (int ia = 0; ia < (1 << W); ia++) begin
      for (int ib = 0; ib < (1 << W); ib++) begin
        send(W'(ia), W'(ib), 1'b1);
        recv(int'($urandom_range(0, 2)), 1'b1, 1'b0);
      end
    end

    check("scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
